mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the five-stage MIPS pipeline. It sits beside the ALU in the E stage, accepts MDU instructions (mult, multu, div, divu, mthi, mtlo, mfhi, mflo), and owns the HI/LO registers. It models the fixed execution latency with a state machine and counter, and drives the stall request that freezes F/D while the unit is occupied. The mfhi/mflo read value feeds the M-stage register and reaches W as the MULDIV result.

---
 rtl/mdu_sequencer.sv | 116 +++++++++++
 tb/tb_mdu_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: owns HI/LO, models the
// fixed mult/div latency and requests F/D stalls while a result is pending.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] res_hi, res_lo, res_hi_next, res_lo_next;
  logic [31:0] hi_next, lo_next;

  logic        is_mul, is_div, div_signed;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign is_mul     = (op == 4'd1) || (op == 4'd2);
  assign is_div     = (op == 4'd3) || (op == 4'd4);
  assign div_signed = (op == 4'd3);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divide on magnitudes and fix signs afterwards; this also yields the
  // 0x80000000 / -1 wrap result (quotient 0x80000000, remainder 0) naturally.
  always_comb begin
    a_mag  = (div_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag  = (div_signed && b[31]) ? (~b + 32'd1) : b;
    b_safe = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (div_signed && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    rem    = (div_signed && a[31]) ? (~r_mag + 32'd1) : r_mag;
    if (b == '0) begin
      quot = '1;
      rem  = a;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    res_hi_next = res_hi;
    res_lo_next = res_lo;
    hi_next     = hi;
    lo_next     = lo;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (is_mul) begin
            {res_hi_next, res_lo_next} = (op == 4'd1) ? prod_s : prod_u;
            cnt_next   = 4'(MULT_CYCLES);
            state_next = MUL;
          end else if (is_div) begin
            res_hi_next = rem;
            res_lo_next = quot;
            cnt_next    = 4'(DIV_CYCLES);
            state_next  = DIV;
          end else if (op == 4'd5) begin
            hi_next = a;
          end else if (op == 4'd6) begin
            lo_next = a;
          end
        end
      end
      MUL, DIV: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_next   = '0;
          hi_next    = res_hi;
          lo_next    = res_lo;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      res_hi <= res_hi_next;
      res_lo <= res_lo_next;
      hi     <= hi_next;
      lo     <= lo_next;
    end
  end

  assign busy      = (state != IDLE);
  assign stall_req = d_md_use & (busy | (start & (is_mul | is_div)));
  assign md_rdata  = (op == 4'd7) ? hi : (op == 4'd8) ? lo : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, d_md_use;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] hi, lo, md_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_md_use(d_md_use), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo), .md_rdata(md_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {hi, lo} result of a mult/div computed with plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, ux, uy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      4'd1: begin p = sx * sy; return p; end
      4'd2: begin p = ux * uy; return p; end
      4'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy; r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = ux / uy; r = ux % uy;
        return {r[31:0], q[31:0]};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic du);
    int n;
    logic md;
    logic [63:0] r;
    md = (o >= 4'd1) && (o <= 4'd4);
    n  = (o == 4'd1 || o == 4'd2) ? 5 : (md ? 10 : 0);
    r  = ref_result(o, x, y);
    start = 1'b1; op = o; a = x; b = y; d_md_use = du;
    #1;
    check("stall_start", {31'b0, stall_req}, {31'b0, du & md});
    tick();
    start = 1'b0; op = 4'd0;
    if (o == 4'd5) m_hi = x;
    if (o == 4'd6) m_lo = x;
    for (int i = 0; i < n; i++) begin
      check("busy_during", {31'b0, busy}, 32'd1);
      check("stall_during", {31'b0, stall_req}, {31'b0, du});
      check("hi_hold", hi, m_hi);
      check("lo_hold", lo, m_lo);
      tick();
    end
    if (md) {m_hi, m_lo} = r;
    check("busy_done", {31'b0, busy}, 32'd0);
    check("stall_done", {31'b0, stall_req}, 32'd0);
    check("hi_done", hi, m_hi);
    check("lo_done", lo, m_lo);
    start = 1'b1; op = 4'd7; d_md_use = 1'b1;
    #1;
    check("mfhi", md_rdata, m_hi);
    check("mfhi_nostall", {31'b0, stall_req}, 32'd0);
    op = 4'd8;
    #1;
    check("mflo", md_rdata, m_lo);
    start = 1'b0; op = 4'd0; d_md_use = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{4'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{4'd4, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{4'd5, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFD};
    vecs[9] = '{4'd6, 32'hCAFE_F00D, 32'd0,        32'h1234_5678, 32'hCAFE_F00D};

    // reset wins over a pending mult request
    reset = 1'b1; start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd3; d_md_use = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    check("rst_rdata", md_rdata, 32'd0);
    start = 1'b0; op = 4'd0;
    reset = 1'b0;
    tick();
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'(i % 2));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // ops presented while busy must be ignored
    start = 1'b1; op = 4'd1; a = 32'h0001_0000; b = 32'h0001_0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("ign_busy", {31'b0, busy}, 32'd1);
      start = 1'b1;
      if (i < 2) begin op = 4'd3; a = 32'd100; b = 32'd3; end
      else if (i == 2) begin op = 4'd5; a = 32'hDEAD_BEEF; end
      else begin start = 1'b0; op = 4'd0; end
      tick();
    end
    start = 1'b0; op = 4'd0;
    check("ign_busy_end", {31'b0, busy}, 32'd0);
    check("ign_hi", hi, 32'd1);
    check("ign_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("ign_late_busy", {31'b0, busy}, 32'd0);
    check("ign_late_hi", hi, 32'd1);
    check("ign_late_lo", lo, 32'd0);
    m_hi = 32'd1; m_lo = 32'd0;

    // reset mid-mult at cnt==3 discards the result
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0; op = 4'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("midrst_late_busy", {31'b0, busy}, 32'd0);
    check("midrst_late_hi", hi, 32'd0);
    check("midrst_late_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;

    // randomized back-to-back ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  ro;
      logic [31:0] rx, ry;
      ro = 4'($urandom_range(1, 6));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op(ro, rx, ry, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
